// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the integer register file and its decode neighbours
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_ZERO = 0;

    // Opcodes decode uses to pick operand and destination fields; decode lives outside this block
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_S      = 7'b0100011;
    localparam logic [6:0] OPC_SB     = 7'b1100011;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy bits with issue-over-retire priority and live count
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             we,
    input  logic [AW-1:0]    rd_addr,
    output logic [NREGS-1:0] busy_vec,
    output logic [CW-1:0]    pend_cnt
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    logic             set_ok;
    logic             clr_ok;
    logic             inc;
    logic             dec;
    logic [NREGS-1:0] busy_nxt;

    assign set_ok = iss_valid && ({1'b0, iss_rd} < NREGS_W) && (iss_rd != AW'(REG_ZERO));
    assign clr_ok = we && ({1'b0, rd_addr} < NREGS_W) && (rd_addr != AW'(REG_ZERO));

    // A retire that coincides with a new issue to the same register leaves it busy
    assign inc = set_ok && !busy_vec[iss_rd];
    assign dec = clr_ok && busy_vec[rd_addr] && !(set_ok && (iss_rd == rd_addr));

    always_comb begin
        busy_nxt = busy_vec;
        if (clr_ok) busy_nxt[rd_addr] = 1'b0;
        if (set_ok) busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_vec <= '0;
            pend_cnt <= '0;
        end else begin
            busy_vec <= busy_nxt;
            pend_cnt <= pend_cnt + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write-first bypass, hardwired x0 and scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREAD*AW-1:0]        rs_addr,
    output logic [NREAD*XLEN-1:0]      rs_data,
    output logic [NREAD-1:0]           rs_busy,
    input  logic                       we,
    input  logic [AW-1:0]              rd_addr,
    input  logic [XLEN-1:0]            rd_data,
    input  logic                       iss_valid,
    input  logic [AW-1:0]              iss_rd,
    output logic [NREGS-1:0]           busy_vec,
    output logic [$clog2(NREGS+1)-1:0] pend_cnt
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    assign wr_ok = we && ({1'b0, rd_addr} < NREGS_W) && (rd_addr != AW'(REG_ZERO));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (wr_ok) begin
            regs[rd_addr] <= rd_data;
        end
    end

    // A retiring producer is forwarded, so its consumer neither stalls nor sees stale data
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok;
        logic          hit;

        assign a   = rs_addr[i*AW +: AW];
        assign ok  = ({1'b0, a} < NREGS_W) && (a != AW'(REG_ZERO));
        assign hit = wr_ok && (rd_addr == a);
        assign rs_data[i*XLEN +: XLEN] = !ok ? '0 : (hit ? rd_data : regs[a]);
        assign rs_busy[i] = ok && busy_vec[a] && !hit;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .rd_addr   (rd_addr),
        .busy_vec  (busy_vec),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed bench for regfile_sb at default and 24-register/3-port sizes
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad = 0;

    // default instance: XLEN 32, NREGS 32, NREAD 2
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy_vec;
    logic [5:0]  pend_cnt;

    // small instance: NREGS 24, NREAD 3
    logic [14:0] b_rs_addr;
    logic [95:0] b_rs_data;
    logic [2:0]  b_rs_busy;
    logic        b_we;
    logic [4:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic        b_iss_valid;
    logic [4:0]  b_iss_rd;
    logic [23:0] b_busy_vec;
    logic [4:0]  b_pend_cnt;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_vec(busy_vec), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.XLEN(32), .NREGS(24), .NREAD(3)) dut24 (
        .clk(clk), .reset(reset), .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
        .we(b_we), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .iss_valid(b_iss_valid),
        .iss_rd(b_iss_rd), .busy_vec(b_busy_vec), .pend_cnt(b_pend_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rd_addr = '0; rd_data = '0; iss_valid = 1'b0; iss_rd = '0;
        b_we = 1'b0; b_rd_addr = '0; b_rd_data = '0; b_iss_valid = 1'b0; b_iss_rd = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); rs_addr = '0; b_rs_addr = '0;
        tick(); tick();
        reset = 1'b0;
        rs_addr = {5'd5, 5'd1}; #1;
        total++; if (rs_data !== 64'h0) begin bad++; $display("FAIL reset_rd_1_5 got=%h exp=0", rs_data); end
        total++; if (rs_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", rs_busy); end
        total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
        rs_addr = {5'd31, 5'd31}; #1;
        total++; if (rs_data !== 64'h0) begin bad++; $display("FAIL reset_rd_31 got=%h exp=0", rs_data); end
        // reset lands before the write edge, so the write is discarded
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'hDEADBEEF; #1;
        reset = 1'b1;
        tick();
        reset = 1'b0; idle();
        rs_addr = {5'd7, 5'd7}; tick();
        total++; if (rs_data !== 64'h0) begin bad++; $display("FAIL reset_midwrite_x7 got=%h exp=0", rs_data); end
    endtask

    task automatic test_x0();
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs_addr = {5'd0, 5'd0}; #1;
        total++; if (rs_data !== 64'h0) begin bad++; $display("FAIL x0_same got=%h exp=0", rs_data); end
        tick(); idle(); #1;
        total++; if (rs_data !== 64'h0) begin bad++; $display("FAIL x0_next got=%h exp=0", rs_data); end
    endtask

    task automatic test_bypass();
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'h12345678; rs_addr = {5'd3, 5'd3}; #1;
        total++; if (rs_data !== 64'h12345678_12345678) begin bad++; $display("FAIL bypass_x3 got=%h exp=1234567812345678", rs_data); end
        tick(); idle(); #1;
        total++; if (rs_data !== 64'h12345678_12345678) begin bad++; $display("FAIL array_x3 got=%h exp=1234567812345678", rs_data); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd5; rs_addr = {5'd5, 5'd3}; #1;
        total++; if (rs_busy !== 2'b00) begin bad++; $display("FAIL iss_not_yet got=%b exp=00", rs_busy); end
        tick(); idle(); #1;
        total++; if (rs_busy !== 2'b10) begin bad++; $display("FAIL iss_busy got=%b exp=10", rs_busy); end
        total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL iss_pend got=%0d exp=1", pend_cnt); end
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'hA5; #1;
        total++; if (rs_busy !== 2'b00) begin bad++; $display("FAIL retire_busy got=%b exp=00", rs_busy); end
        total++; if (rs_data[63:32] !== 32'hA5) begin bad++; $display("FAIL retire_data got=%h exp=a5", rs_data[63:32]); end
        total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL retire_pend_same got=%0d exp=1", pend_cnt); end
        tick(); idle(); #1;
        total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL retire_pend_next got=%0d exp=0", pend_cnt); end
        total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL retire_vec got=%h exp=0", busy_vec); end
    endtask

    task automatic test_set_clr();
        iss_valid = 1'b1; iss_rd = 5'd5; tick(); idle();
        we = 1'b1; rd_addr = 5'd5; iss_valid = 1'b1; iss_rd = 5'd5; tick(); idle();
        total++; if (busy_vec !== 32'h20) begin bad++; $display("FAIL same_reg_vec got=%h exp=20", busy_vec); end
        total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL same_reg_pend got=%0d exp=1", pend_cnt); end
        we = 1'b1; rd_addr = 5'd5; iss_valid = 1'b1; iss_rd = 5'd9; tick(); idle();
        total++; if (busy_vec !== 32'h200) begin bad++; $display("FAIL move_vec got=%h exp=200", busy_vec); end
        total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL move_pend got=%0d exp=1", pend_cnt); end
        iss_valid = 1'b1; iss_rd = 5'd0; tick(); idle();
        total++; if (busy_vec !== 32'h200) begin bad++; $display("FAIL iss_x0_vec got=%h exp=200", busy_vec); end
        we = 1'b1; rd_addr = 5'd12; tick(); idle();
        total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL clr_idle_pend got=%0d exp=1", pend_cnt); end
        iss_valid = 1'b1; iss_rd = 5'd31; tick(); idle();
        total++; if (pend_cnt !== 6'd2 || busy_vec !== 32'h80000200) begin bad++; $display("FAIL iss_x31 got=%0d/%h exp=2/80000200", pend_cnt, busy_vec); end
        we = 1'b1; rd_addr = 5'd9; tick(); we = 1'b1; rd_addr = 5'd31; tick(); idle();
        total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL drain_pend got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_out_of_range();
        b_we = 1'b1; b_rd_addr = 5'd28; b_rd_data = 32'hCAFEF00D;
        b_iss_valid = 1'b1; b_iss_rd = 5'd28; b_rs_addr = {5'd28, 5'd28, 5'd28}; #1;
        total++; if (b_rs_data !== 96'h0) begin bad++; $display("FAIL oor_bypass got=%h exp=0", b_rs_data); end
        tick(); idle(); #1;
        total++; if (b_rs_data !== 96'h0) begin bad++; $display("FAIL oor_array got=%h exp=0", b_rs_data); end
        total++; if (b_busy_vec !== 24'h0 || b_pend_cnt !== 5'd0) begin bad++; $display("FAIL oor_sb got=%h/%0d exp=0/0", b_busy_vec, b_pend_cnt); end
        b_we = 1'b1; b_rd_addr = 5'd23; b_rd_data = 32'h00C0FFEE; tick(); idle();
        b_iss_valid = 1'b1; b_iss_rd = 5'd23; tick(); idle();
        b_rs_addr = {5'd23, 5'd28, 5'd0}; #1;
        total++; if (b_rs_data[95:64] !== 32'h00C0FFEE || b_rs_busy !== 3'b100) begin bad++; $display("FAIL top_reg got=%h/%b exp=00c0ffee/100", b_rs_data[95:64], b_rs_busy); end
        b_we = 1'b1; b_rd_addr = 5'd23; tick(); idle();
    endtask

    task automatic test_random();
        logic [23:0] model;
        int          cnt;
        int          errs;
        model = '0; errs = 0;
        for (int n = 0; n < 300; n++) begin
            b_iss_valid = 1'($urandom_range(0, 1)); b_iss_rd = 5'($urandom_range(0, 31));
            b_we = 1'($urandom_range(0, 1)); b_rd_addr = 5'($urandom_range(0, 31));
            if (b_we && b_rd_addr != 0 && b_rd_addr < 24) model[b_rd_addr] = 1'b0;
            if (b_iss_valid && b_iss_rd != 0 && b_iss_rd < 24) model[b_iss_rd] = 1'b1;
            tick();
            cnt = $countones(model);
            if (b_busy_vec !== model || int'(b_pend_cnt) != cnt) begin
                errs++;
                if (errs < 4) $display("FAIL rand_step%0d got=%h/%0d exp=%h/%0d", n, b_busy_vec, b_pend_cnt, model, cnt);
            end
        end
        idle();
        total++; if (errs != 0) begin bad++; $display("FAIL rand_stream errors=%0d exp=0", errs); end
    endtask

    initial begin
        test_reset();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_set_clr();
        test_out_of_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with configurable width, depth and read-port count, write-first bypass, hardwired-zero x0 and a pending-write scoreboard. It sits between decode and writeback in the RISC-V core: decode reads operands and registers the destination of each long-latency (load) instruction, writeback retires it, and the per-port busy flags drive the hazard/stall logic.

## Interface
Parameters:
- XLEN, 32, data width of every register
- NREGS, 32, number of architectural registers (2..64, need not be a power of two)
- NREAD, 2, number of independent read ports (1..4)
- AW, $clog2(NREGS), derived register-address width; not overridden

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  asynchronous, active-high; clears array, scoreboard and counter
- rs_addr  input  NREAD*AW  read addresses, port i at [i*AW +: AW]
- rs_data  output  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rs_busy  output  NREAD  port i operand has an outstanding producer
- we  input  1  writeback enable
- rd_addr  input  AW  writeback destination
- rd_data  input  XLEN  writeback data
- iss_valid  input  1  a long-latency instruction issues this cycle
- iss_rd  input  AW  its destination register
- busy_vec  output  NREGS  scoreboard bit per register
- pend_cnt  output  $clog2(NREGS+1)  number of set scoreboard bits

## Operation
- Register 0 reads 0, is never written, is never marked busy.
- Addresses >= NREGS: reads return 0, rs_busy 0; writes and issues ignored.
- Read (combinational, every port independent): if we && rd_addr == rs_addr[i] && rd_addr valid and nonzero, rs_data[i] = rd_data (write-first bypass); else array contents.
- Write: at posedge, if we and rd_addr valid and nonzero, array[rd_addr] <= rd_data.
- Scoreboard, per register r != 0, at posedge:
  - set = iss_valid && iss_rd == r; clr = we && rd_addr == r
  - set wins over clr (new producer issued as old one retires)
  - clr on a non-busy register: no effect; set on a busy register: stays busy
- rs_busy[i] = busy[rs_addr[i]] && !(we && rd_addr == rs_addr[i]); a retiring producer's value is bypassed, so the consumer is not stalled.
- pend_cnt tracks popcount(busy_vec) incrementally: +1 on a 0->1 transition, -1 on 1->0, net 0 when both occur on different registers in one cycle; never exceeds NREGS-1, never underflows.

## Timing
- Reset (asynchronous, immediate): all registers 0, busy_vec 0, pend_cnt 0, rs_busy 0; rs_data 0 unless bypassing a same-cycle write.
- Reset asserted mid-operation discards pending writes and all busy bits; first posedge after deassertion operates normally.
- Read latency 0 cycles; write visible from array on the cycle after we, and in the same cycle via bypass.
- Issue: busy bit and rs_busy visible from the cycle after iss_valid; pend_cnt updates in that same cycle.
- Retire: rs_busy drops in the we cycle (combinational); busy_vec and pend_cnt update the cycle after.
- No handshake back-pressure; the block never stalls its inputs.

## Structure
- Shared package regfile_pkg: XLEN default, REG_ZERO address constant, RISC-V opcode localparams (R, I-load, I-ALU, S, SB) used by decode for operand/destination extraction; decode stays outside this block.
- Sub-module regfile_scoreboard: busy_vec, set/clr priority, pend_cnt; parameters NREGS, AW. The top holds the array, bypass and read muxes.

## Test plan
- Reset then read all ports at 1, 5, 31 -> rs_data 0, rs_busy 0, pend_cnt 0; assert reset mid-write to x7 = 0xDEADBEEF -> x7 reads 0 afterwards.
- we, rd_addr 0, rd_data 0xFFFFFFFF; then read x0 -> 0, both same cycle and next cycle.
- Write x3 = 0x12345678 while port 0 and port 1 read x3 in the same cycle -> both return 0x12345678; next cycle array read also 0x12345678.
- iss_valid x5; next cycle port 1 reads x5 -> rs_busy[1] 1, pend_cnt 1; retire x5 = 0xA5 -> rs_busy[1] 0 and rs_data 0xA5 that cycle, pend_cnt 0 next cycle.
- Same cycle: retire x5 and issue x5 -> busy_vec[5] stays 1, pend_cnt unchanged; retire x5 and issue x9 -> pend_cnt unchanged, busy moves 5->9; issue x0 -> no busy bit.
- NREGS=24, NREAD=3: write/issue address 28 -> ignored, reads of 28 return 0; random issue/retire streams -> pend_cnt always equals popcount(busy_vec).
